// File: rtl/cp0_timer_ctrl_pkg.sv
// cp0_pkg: shared CP0 register addresses, field positions and exception codes
package cp0_pkg;
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;
    localparam int IE_BIT  = 0;
    localparam int EXL_BIT = 1;
    localparam int EXC_LSB = 2;
    localparam int EXC_MSB = 6;
    localparam int IP_LSB  = 10;
    localparam int TI_BIT  = 30;
    localparam int BD_BIT  = 31;
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;
endpackage

// File: rtl/cp0_timer_ctrl_if.sv
// cp0_timer_ctrl_if: commit-stage bus between the pipeline and CP0
interface cp0_timer_ctrl_if #(
    parameter int NUM_HWINT = 5,
    parameter int EXC_W     = 5
);
    logic [4:0]           A1;
    logic [4:0]           A2;
    logic                 WE;
    logic [31:0]          Din;
    logic [31:0]          PC;
    logic                 BD;
    logic [EXC_W-1:0]     ExcCodeIn;
    logic [NUM_HWINT-1:0] HWInt;
    logic                 EXLClr;
    logic                 Req;
    logic [31:0]          EPCOut;
    logic [31:0]          Dout;
    logic                 TimerIrq;
    modport master (
        output A1, A2, WE, Din, PC, BD, ExcCodeIn, HWInt, EXLClr,
        input  Req, EPCOut, Dout, TimerIrq
    );
    modport slave (
        input  A1, A2, WE, Din, PC, BD, ExcCodeIn, HWInt, EXLClr,
        output Req, EPCOut, Dout, TimerIrq
    );
endinterface

// File: rtl/cp0_timer_ctrl_count_cmp.sv
// cp0_count_cmp: prescaled Count, Compare and the sticky timer-interrupt flag
module cp0_count_cmp #(
    parameter int CNT_DIV_LOG2 = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam logic [CNT_DIV_LOG2:0] DIV_MAX = {(CNT_DIV_LOG2+1){1'b1}} >> 1;
    logic [CNT_DIV_LOG2:0] div;
    logic                  tick;
    logic                  eq;
    logic                  eq_d;
    assign tick = div == DIV_MAX;
    assign eq   = count == compare;
    // eq_d resets high because Count and Compare start equal, which is not a transition into a match
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div     <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
            eq_d    <= 1'b1;
        end else begin
            div     <= (count_we | tick) ? '0 : div + 1'b1;
            count   <= count_we ? din : count + {31'b0, tick};
            compare <= compare_we ? din : compare;
            ti      <= compare_we ? 1'b0 : ti | (eq & ~eq_d);
            eq_d    <= eq;
        end
    end
endmodule

// File: rtl/cp0_timer_ctrl.sv
// cp0_timer_ctrl: CP0 register file with interrupt/exception resolution and Count/Compare timer
module cp0_timer_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT    = 5,
    parameter int          EXC_W        = 5,
    parameter int          SYNC_STAGES  = 2,
    parameter int          CNT_DIV_LOG2 = 0,
    parameter logic [31:0] PRID         = 32'h0000_2023
) (
    input logic             clk,
    input logic             reset_n,
    cp0_timer_ctrl_if.slave bus
);
    localparam int IPW = NUM_HWINT + 1;
    logic [NUM_HWINT-1:0] chain [SYNC_STAGES+1];
    logic [31:0]          sr;
    logic [31:0]          epc;
    logic                 bd;
    logic [EXC_W-1:0]     exc;
    logic [31:0]          count;
    logic [31:0]          compare;
    logic                 ti;
    logic [IPW-1:0]       ip;
    logic [IPW-1:0]       im;
    logic                 int_req;
    logic                 exc_req;
    logic                 we_ok;
    logic                 count_we;
    logic                 compare_we;
    logic [31:0]          cause;
    assign ip = {ti, chain[SYNC_STAGES]};
    assign im = sr[IP_LSB +: IPW];
    cp0_count_cmp #(.CNT_DIV_LOG2(CNT_DIV_LOG2)) u_count_cmp (
        .clk        (clk),
        .reset_n    (reset_n),
        .count_we   (count_we),
        .compare_we (compare_we),
        .din        (bus.Din),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
    // request resolution, bypassed EPC, write qualification and read mux
    always_comb begin
        int_req        = |(ip & im) & sr[IE_BIT] & ~sr[EXL_BIT];
        exc_req        = (bus.ExcCodeIn != '0) & ~sr[EXL_BIT];
        bus.Req        = int_req | exc_req;
        bus.EPCOut     = bus.Req ? (bus.BD ? bus.PC - 32'd4 : bus.PC) : epc;
        we_ok          = bus.WE & ~bus.Req & ~bus.EXLClr;
        count_we       = we_ok & (bus.A2 == CP0_COUNT);
        compare_we     = we_ok & (bus.A2 == CP0_COMPARE);
        cause          = '0;
        cause[BD_BIT]  = bd;
        cause[TI_BIT]  = ti;
        cause[IP_LSB +: IPW]  = ip;
        cause[EXC_LSB +: EXC_W] = exc;
        bus.Dout       = (bus.A1 == CP0_COUNT)   ? count :
                         (bus.A1 == CP0_COMPARE) ? compare :
                         (bus.A1 == CP0_SR)      ? sr :
                         (bus.A1 == CP0_CAUSE)   ? cause :
                         (bus.A1 == CP0_EPC)     ? bus.EPCOut :
                         (bus.A1 == CP0_PRID)    ? PRID : '0;
        bus.TimerIrq   = ti;
    end
    // HWInt synchroniser; the last stage is the IP latch and updates unconditionally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= SYNC_STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= bus.HWInt;
            for (int i = 1; i <= SYNC_STAGES; i++) chain[i] <= chain[i-1];
        end
    end
    // SR/Cause/EPC update: a taken request beats eret, which beats mtc0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '0;
            epc <= '0;
            bd  <= 1'b0;
            exc <= '0;
        end else if (bus.Req) begin
            sr[EXL_BIT] <= 1'b1;
            bd          <= bus.BD;
            epc         <= bus.EPCOut;
            exc         <= int_req ? '0 : bus.ExcCodeIn;
        end else if (bus.EXLClr) begin
            sr[EXL_BIT] <= 1'b0;
        end else if (bus.WE) begin
            if (bus.A2 == CP0_SR) sr <= bus.Din;
            if (bus.A2 == CP0_EPC) epc <= {bus.Din[31:2], 2'b00};
        end
    end
endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// tb_cp0_timer_ctrl: table-driven register checks plus directed interrupt, timer and reset sequences
module tb_cp0_timer_ctrl;
    localparam logic [31:0] PRID = 32'h0000_2023;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;
    cp0_timer_ctrl_if bus ();
    cp0_timer_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_t;
    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        we;
        logic [31:0] din;
        logic [31:0] dout;
        logic [31:0] epc;
        logic        ti;
    } vec_t;
    sb_t  q[$];
    vec_t vt[16];
    int   checks = 0;
    int   errors = 0;
    task automatic expect_out(input string name, input int sel, input logic [31:0] v);
        sb_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask
    task automatic exp_req(input string name, input logic v);
        expect_out(name, 0, {31'b0, v});
    endtask
    task automatic exp_epc(input string name, input logic [31:0] v);
        expect_out(name, 1, v);
    endtask
    task automatic exp_dout(input string name, input logic [31:0] v);
        expect_out(name, 2, v);
    endtask
    task automatic exp_ti(input string name, input logic v);
        expect_out(name, 3, {31'b0, v});
    endtask
    task automatic flush();
        sb_t e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            act = (e.sel == 0) ? {31'b0, bus.Req} :
                  (e.sel == 1) ? bus.EPCOut :
                  (e.sel == 2) ? bus.Dout : {31'b0, bus.TimerIrq};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
        end
    endtask
    task automatic cyc();
        @(negedge clk);
        flush();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.WE = 1'b0;
        bus.EXLClr = 1'b0;
        bus.ExcCodeIn = '0;
        bus.BD = 1'b0;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.WE = 1'b1;
        bus.A2 = a;
        bus.Din = d;
    endtask
    initial begin
        vt[0]  = '{5'd12, 5'd12, 1'b1, 32'h0000_0401, 32'h0,         32'h0,    1'b0};
        vt[1]  = '{5'd12, 5'd0,  1'b0, 32'h0,         32'h0000_0401, 32'h0,    1'b0};
        vt[2]  = '{5'd14, 5'd14, 1'b1, 32'h0000_3007, 32'h0,         32'h0,    1'b0};
        vt[3]  = '{5'd14, 5'd0,  1'b0, 32'h0,         32'h0000_3004, 32'h3004, 1'b0};
        vt[4]  = '{5'd15, 5'd0,  1'b0, 32'h0,         PRID,          32'h3004, 1'b0};
        vt[5]  = '{5'd13, 5'd13, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h3004, 1'b0};
        vt[6]  = '{5'd13, 5'd0,  1'b0, 32'h0,         32'h0,         32'h3004, 1'b0};
        vt[7]  = '{5'd15, 5'd15, 1'b1, 32'h0,         PRID,          32'h3004, 1'b0};
        vt[8]  = '{5'd3,  5'd3,  1'b1, 32'h0000_FFFF, 32'h0,         32'h3004, 1'b0};
        vt[9]  = '{5'd3,  5'd0,  1'b0, 32'h0,         32'h0,         32'h3004, 1'b0};
        vt[10] = '{5'd0,  5'd9,  1'b1, 32'hFFFF_FFFF, 32'h0,         32'h3004, 1'b0};
        vt[11] = '{5'd9,  5'd0,  1'b0, 32'h0,         32'hFFFF_FFFF, 32'h3004, 1'b0};
        vt[12] = '{5'd9,  5'd0,  1'b0, 32'h0,         32'h0,         32'h3004, 1'b0};
        vt[13] = '{5'd13, 5'd0,  1'b0, 32'h0,         32'h4000_8000, 32'h3004, 1'b1};
        vt[14] = '{5'd9,  5'd11, 1'b1, 32'h0000_0100, 32'h2,         32'h3004, 1'b1};
        vt[15] = '{5'd11, 5'd0,  1'b0, 32'h0,         32'h0000_0100, 32'h3004, 1'b0};
        idle();
        bus.A1 = 5'd15;
        bus.A2 = 5'd0;
        bus.Din = '0;
        bus.PC = '0;
        bus.HWInt = '0;
        #1 reset_n = 1'b0;
        #1;
        exp_req("rst_req", 1'b0);
        exp_ti("rst_ti", 1'b0);
        exp_epc("rst_epc", 32'h0);
        exp_dout("rst_prid", PRID);
        flush();
        bus.A1 = 5'd9;
        #1;
        exp_dout("rst_count", 32'h0);
        flush();
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            idle();
            bus.A1 = vt[i].a1;
            if (vt[i].we) wr(vt[i].a2, vt[i].din);
            exp_dout($sformatf("vec%0d_dout", i), vt[i].dout);
            exp_epc($sformatf("vec%0d_epc", i), vt[i].epc);
            exp_ti($sformatf("vec%0d_ti", i), vt[i].ti);
            exp_req($sformatf("vec%0d_req", i), 1'b0);
            cyc();
        end
        idle();
        bus.A1 = 5'd13;
        bus.PC = 32'h0000_1000;
        bus.HWInt = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            exp_req($sformatf("hw_wait%0d_req", k), 1'b0);
            exp_dout($sformatf("hw_wait%0d_cause", k), 32'h0);
            cyc();
            bus.HWInt = '0;
        end
        exp_req("hw_take_req", 1'b1);
        exp_epc("hw_take_epc", 32'h0000_1000);
        exp_dout("hw_take_cause", 32'h0000_0400);
        cyc();
        bus.A1 = 5'd12;
        exp_req("hw_exl_req", 1'b0);
        exp_dout("hw_exl_sr", 32'h0000_0403);
        exp_epc("hw_exl_epc", 32'h0000_1000);
        cyc();
        bus.A1 = 5'd13;
        exp_dout("hw_exc_cause", 32'h0);
        cyc();
        bus.EXLClr = 1'b1;
        bus.A1 = 5'd14;
        exp_dout("hw_eret_epc", 32'h0000_1000);
        exp_req("hw_eret_req", 1'b0);
        cyc();
        idle();
        bus.A1 = 5'd12;
        exp_dout("hw_after_sr", 32'h0000_0401);
        exp_req("hw_after_req", 1'b0);
        cyc();
        bus.A1 = 5'd13;
        bus.HWInt = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            exp_req($sformatf("both_wait%0d_req", k), 1'b0);
            cyc();
        end
        bus.ExcCodeIn = 5'd12;
        bus.BD = 1'b1;
        bus.PC = 32'h0000_3008;
        exp_req("both_req", 1'b1);
        exp_epc("both_epc", 32'h0000_3004);
        cyc();
        idle();
        bus.HWInt = '0;
        exp_dout("both_cause", 32'h8000_0400);
        exp_req("both_exl_req", 1'b0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            exp_req($sformatf("both_hold%0d_req", k), 1'b0);
            cyc();
        end
        bus.EXLClr = 1'b1;
        exp_req("both_eret_req", 1'b0);
        cyc();
        idle();
        wr(5'd12, 32'h0000_0001);
        exp_req("mask_wr_req", 1'b0);
        cyc();
        idle();
        bus.HWInt = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            exp_req($sformatf("mask_wait%0d_req", k), 1'b0);
            cyc();
        end
        bus.ExcCodeIn = 5'd12;
        bus.BD = 1'b1;
        bus.PC = 32'h0000_3008;
        exp_req("mask_req", 1'b1);
        exp_epc("mask_epc", 32'h0000_3004);
        cyc();
        idle();
        bus.HWInt = '0;
        exp_dout("mask_cause", 32'h8000_0430);
        cyc();
        bus.ExcCodeIn = 5'd4;
        bus.PC = 32'h0000_5000;
        bus.A1 = 5'd14;
        exp_req("exl_adel_req", 1'b0);
        exp_epc("exl_adel_epc", 32'h0000_3004);
        exp_dout("exl_adel_dout", 32'h0000_3004);
        cyc();
        idle();
        exp_dout("exl_epc_kept", 32'h0000_3004);
        cyc();
        bus.EXLClr = 1'b1;
        wr(5'd12, 32'hFFFF_FFFF);
        bus.A1 = 5'd12;
        exp_dout("eret_we_sr_before", 32'h0000_0003);
        exp_req("eret_we_req", 1'b0);
        cyc();
        idle();
        exp_dout("eret_we_sr_after", 32'h0000_0001);
        cyc();
        wr(5'd11, 32'd5);
        bus.A1 = 5'd0;
        exp_ti("tmr_cmp_ti", 1'b0);
        cyc();
        wr(5'd9, 32'd0);
        cyc();
        wr(5'd12, 32'h0000_8001);
        bus.PC = 32'h0000_2000;
        bus.A1 = 5'd9;
        exp_dout("tmr_count0", 32'd0);
        exp_ti("tmr_ti0", 1'b0);
        exp_req("tmr_req0", 1'b0);
        cyc();
        idle();
        for (int k = 1; k <= 5; k++) begin
            exp_dout($sformatf("tmr_count%0d", k), k);
            exp_ti($sformatf("tmr_ti%0d", k), 1'b0);
            exp_req($sformatf("tmr_req%0d", k), 1'b0);
            cyc();
        end
        exp_ti("tmr_fire_ti", 1'b1);
        exp_req("tmr_fire_req", 1'b1);
        exp_epc("tmr_fire_epc", 32'h0000_2000);
        cyc();
        bus.A1 = 5'd13;
        exp_dout("tmr_cause", 32'h4000_8000);
        exp_req("tmr_exl_req", 1'b0);
        exp_ti("tmr_sticky_ti", 1'b1);
        cyc();
        wr(5'd11, 32'h0000_1000);
        exp_ti("tmr_clr_ti_before", 1'b1);
        cyc();
        idle();
        wr(5'd9, 32'h0000_0FFE);
        bus.HWInt = 5'b00001;
        exp_ti("tmr_clr_ti_after", 1'b0);
        cyc();
        idle();
        bus.A1 = 5'd12;
        for (int k = 0; k < 3; k++) begin
            exp_ti($sformatf("tmr2_wait%0d_ti", k), 1'b0);
            cyc();
        end
        @(negedge clk);
        exp_ti("tmr2_fire_ti", 1'b1);
        flush();
        #2 reset_n = 1'b0;
        #1;
        exp_req("arst_req", 1'b0);
        exp_ti("arst_ti", 1'b0);
        exp_epc("arst_epc", 32'h0);
        exp_dout("arst_sr", 32'h0);
        flush();
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.A1 = 5'd13;
        for (int k = 0; k < 3; k++) begin
            exp_dout($sformatf("rel_wait%0d_cause", k), 32'h0);
            cyc();
        end
        exp_dout("rel_ip_cause", 32'h0000_0400);
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
